// File: rtl/ax_cycle_budget_ctrl.sv
// Cycle-budget controller for approximate regions: free-running counter,
// region begin latch, threshold CSR and saturating budget-expiry counter.
module ax_cycle_budget_ctrl #(
    parameter int          DATA_WIDTH        = 32,
    parameter int          COMMIT_WIDTH      = 2,
    parameter int unsigned DEFAULT_THRESHOLD = 1000,
    parameter int          EXP_CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csrWE,
    input  logic                    csrSel,
    input  logic [DATA_WIDTH-1:0]   csrWData,
    output logic [DATA_WIDTH-1:0]   csrRData,
    input  logic [COMMIT_WIDTH-1:0] commitValid,
    input  logic [COMMIT_WIDTH-1:0] commitAxBegin,
    input  logic [COMMIT_WIDTH-1:0] commitAxEnd,
    output logic [DATA_WIDTH-1:0]   cycleCounter,
    output logic [DATA_WIDTH-1:0]   beginCycle,
    output logic [DATA_WIDTH-1:0]   threshold,
    output logic                    regionActive,
    output logic                    budgetExpired
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [EXP_CNT_WIDTH-1:0] exp_cnt;
    logic [DATA_WIDTH-1:0]    elapsed;
    logic                     win_begin;
    logic                     win_end;
    logic                     over_budget;
    logic                     exp_inc;
    logic                     exp_clr;

    // Later slots are younger, so the last valid marker in the group wins.
    always_comb begin
        win_begin = 1'b0;
        win_end   = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commitValid[i] && (commitAxBegin[i] || commitAxEnd[i])) begin
                win_end   = commitAxEnd[i];
                win_begin = !commitAxEnd[i];
            end
        end
    end

    assign elapsed     = cycleCounter - beginCycle;
    assign over_budget = elapsed > threshold;
    assign exp_clr     = csrWE && csrSel;

    always_comb begin
        state_d = state_q;
        exp_inc = 1'b0;
        if (win_begin) begin
            state_d = S_ACTIVE;
        end else if (win_end) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_ACTIVE: begin
                    if (over_budget) begin
                        state_d = S_EXPIRED;
                        exp_inc = 1'b1;
                    end
                end
                S_IDLE:    state_d = S_IDLE;
                S_EXPIRED: state_d = S_EXPIRED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cycleCounter  <= '0;
            beginCycle    <= '0;
            threshold     <= DATA_WIDTH'(DEFAULT_THRESHOLD);
            regionActive  <= 1'b0;
            budgetExpired <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycleCounter  <= cycleCounter + DATA_WIDTH'(1);
            regionActive  <= state_d != S_IDLE;
            budgetExpired <= state_d == S_EXPIRED;
            if (win_begin) begin
                beginCycle <= cycleCounter;
            end
            if (csrWE && !csrSel) begin
                threshold <= csrWData;
            end
        end
    end

    // A clear in the same cycle as an expiry discards that expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_cnt <= '0;
        end else if (exp_clr) begin
            exp_cnt <= '0;
        end else if (exp_inc && (exp_cnt != '1)) begin
            exp_cnt <= exp_cnt + EXP_CNT_WIDTH'(1);
        end
    end

    assign csrRData = csrSel ? DATA_WIDTH'(exp_cnt) : threshold;

endmodule

// File: tb/tb_ax_cycle_budget_ctrl.sv
// Scoreboard bench for ax_cycle_budget_ctrl: narrow counter so the
// wrap case is reachable, small expiry counter so saturation is too.
module tb_ax_cycle_budget_ctrl;

    localparam int     DW   = 12;
    localparam int     CW   = 2;
    localparam int     DT   = 1000;
    localparam int     EW   = 4;
    localparam longint M    = 64'd1 << DW;
    localparam longint EMAX = (64'd1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          csrWE;
    logic          csrSel;
    logic [DW-1:0] csrWData;
    logic [DW-1:0] csrRData;
    logic [CW-1:0] commitValid;
    logic [CW-1:0] commitAxBegin;
    logic [CW-1:0] commitAxEnd;
    logic [DW-1:0] cycleCounter;
    logic [DW-1:0] beginCycle;
    logic [DW-1:0] threshold;
    logic          regionActive;
    logic          budgetExpired;

    always #5 clk = ~clk;

    ax_cycle_budget_ctrl #(
        .DATA_WIDTH       (DW),
        .COMMIT_WIDTH     (CW),
        .DEFAULT_THRESHOLD(DT),
        .EXP_CNT_WIDTH    (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csrWE        (csrWE),
        .csrSel       (csrSel),
        .csrWData     (csrWData),
        .csrRData     (csrRData),
        .commitValid  (commitValid),
        .commitAxBegin(commitAxBegin),
        .commitAxEnd  (commitAxEnd),
        .cycleCounter (cycleCounter),
        .beginCycle   (beginCycle),
        .threshold    (threshold),
        .regionActive (regionActive),
        .budgetExpired(budgetExpired)
    );

    typedef struct {
        longint cnt;
        longint bc;
        longint thr;
        longint act;
        longint exp;
        longint rd;
    } snap_t;

    snap_t  sbq[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference state: time now, region start time, budget, event tally.
    longint m_cnt, m_bc, m_thr, m_ec;
    bit     m_act, m_exp;

    function automatic void chk(string nm, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_bc  = 0;
        m_thr = DT;
        m_ec  = 0;
        m_act = 0;
        m_exp = 0;
    endfunction

    function automatic snap_t snap(bit sel);
        snap_t s;
        s.cnt = m_cnt;
        s.bc  = m_bc;
        s.thr = m_thr;
        s.act = longint'(m_act);
        s.exp = longint'(m_exp);
        s.rd  = sel ? m_ec : m_thr;
        return s;
    endfunction

    function automatic void model_step(bit we, bit sel, longint wd,
                                       bit [CW-1:0] v, bit [CW-1:0] b,
                                       bit [CW-1:0] e);
        int  win = 0;
        bit  inc = 0;
        longint el;
        for (int i = 0; i < CW; i++) begin
            if (v[i] && (b[i] || e[i])) win = e[i] ? 2 : 1;
        end
        el = (m_cnt - m_bc + M) % M;
        if (win == 1) begin
            m_bc  = m_cnt;
            m_act = 1;
            m_exp = 0;
        end else if (win == 2) begin
            m_act = 0;
            m_exp = 0;
        end else if (m_act && !m_exp && el > m_thr) begin
            m_exp = 1;
            inc   = 1;
        end
        if (we && !sel) m_thr = wd % M;
        if (we && sel) m_ec = 0;
        else if (inc && m_ec < EMAX) m_ec = m_ec + 1;
        m_cnt = (m_cnt + 1) % M;
    endfunction

    task automatic drive(bit we, bit sel, longint wd,
                         bit [CW-1:0] v, bit [CW-1:0] b, bit [CW-1:0] e);
        csrWE         = we;
        csrSel        = sel;
        csrWData      = DW'(wd);
        commitValid   = v;
        commitAxBegin = b;
        commitAxEnd   = e;
        sbq.push_back(snap(sel));
        model_step(we, sel, wd, v, b, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n, bit sel);
        for (int i = 0; i < n; i++) drive(0, sel, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        snap_t s;
        if (sbq.size() != 0) begin
            s = sbq.pop_front();
            chk("cycleCounter", longint'(cycleCounter), s.cnt);
            chk("beginCycle", longint'(beginCycle), s.bc);
            chk("threshold", longint'(threshold), s.thr);
            chk("regionActive", longint'(regionActive), s.act);
            chk("budgetExpired", longint'(budgetExpired), s.exp);
            chk("csrRData", longint'(csrRData), s.rd);
        end
    end

    initial begin
        rst = 1'b1;
        csrWE = 0; csrSel = 0; csrWData = '0;
        commitValid = '0; commitAxBegin = '0; commitAxEnd = '0;
        model_reset();
        #2;
        chk("rst_cnt", longint'(cycleCounter), 0);
        chk("rst_thr", longint'(csrRData), DT);
        chk("rst_act", longint'(regionActive), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        idle(10, 0);
        chk("idle10_cnt", longint'(cycleCounter), 10);
        chk("idle10_thr", longint'(threshold), DT);
        chk("idle10_exp", longint'(budgetExpired), 0);

        drive(1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 20 && m_cnt != 20; i++) idle(1, 0);
        drive(0, 0, 0, 2'b01, 2'b01, 2'b00);
        chk("begin_bc", longint'(beginCycle), 20);
        chk("begin_act", longint'(regionActive), 1);
        idle(3, 1);
        chk("pre_exp", longint'(budgetExpired), 0);
        idle(1, 1);
        chk("exp_at25_cnt", longint'(cycleCounter), 25);
        chk("exp_at25", longint'(budgetExpired), 1);
        csrSel = 1;
        #1 chk("exp_count1", longint'(csrRData), 1);

        drive(0, 0, 0, 2'b11, 2'b01, 2'b10);
        chk("b0e1_idle", longint'(regionActive), 0);
        drive(0, 0, 0, 2'b11, 2'b10, 2'b01);
        chk("e0b1_act", longint'(regionActive), 1);
        drive(0, 0, 0, 2'b11, 2'b00, 2'b01);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b00);
        chk("invalid_begin", longint'(regionActive), 0);
        drive(0, 0, 0, 2'b11, 2'b11, 2'b00);

        drive(1, 0, 100, 0, 0, 0);
        drive(0, 0, 0, 2'b01, 2'b01, 2'b00);
        idle(49, 0);
        drive(1, 0, 10, 0, 0, 0);
        idle(1, 1);
        chk("thr_cut_exp", longint'(budgetExpired), 1);

        drive(1, 1, 0, 2'b01, 2'b01, 2'b00);
        drive(1, 0, 100, 0, 0, 0);
        idle(48, 0);
        drive(1, 0, 10, 0, 0, 0);
        drive(0, 1, 0, 2'b10, 2'b00, 2'b10);
        chk("end_beats_exp", longint'(regionActive), 0);
        chk("end_no_count", longint'(csrRData), 0);

        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 18; k++) begin
            drive(0, 1, 0, 2'b01, 2'b01, 2'b00);
            idle(2, 1);
        end
        chk("sat_count", longint'(csrRData), EMAX);
        drive(0, 1, 0, 2'b01, 2'b01, 2'b00);
        drive(1, 1, 0, 0, 0, 0);
        chk("clear_wins", longint'(csrRData), 0);

        for (int i = 0; i < 3000; i++) begin
            bit          we  = ($urandom_range(0, 99) < 8);
            bit          sel = ($urandom_range(0, 3) == 0);
            bit [CW-1:0] v   = CW'($urandom);
            bit [CW-1:0] b;
            bit [CW-1:0] e;
            for (int j = 0; j < CW; j++) begin
                b[j] = ($urandom_range(0, 19) == 0);
                e[j] = ($urandom_range(0, 29) == 0);
            end
            drive(we, sel, $urandom_range(0, 12), v, b, e);
        end

        drive(1, 0, 5, 2'b01, 2'b00, 2'b01);
        for (int i = 0; i < 5000 && m_cnt != M - 2; i++) idle(1, 0);
        drive(0, 0, 0, 2'b01, 2'b01, 2'b00);
        for (int i = 0; i < 20 && !m_exp; i++) idle(1, 1);
        chk("wrap_exp_cnt", longint'(cycleCounter), 5);
        chk("wrap_exp", longint'(budgetExpired), 1);

        drive(0, 1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", longint'(cycleCounter), 0);
        chk("arst_bc", longint'(beginCycle), 0);
        chk("arst_thr", longint'(threshold), DT);
        chk("arst_act", longint'(regionActive), 0);
        chk("arst_exp", longint'(budgetExpired), 0);
        chk("arst_ec", longint'(csrRData), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        idle(3, 0);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) chk("sb_drain", longint'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
